ray_frame_scheduler: RTL
========================

Name: ray_frame_scheduler

Overview:
- Sequences the per-frame raycasting pipeline (ray calculation → DDA-in FIFO → DDA → DDA-out FIFO → transformation → frame buffer).
- Each video frame it snapshots the player pose, issues column indices 0..SCREEN_WIDTH-1 exactly once under a valid/ready handshake, and limits in-flight columns by credit.
- After the transformer reports the last pixel, it requests a frame-buffer swap and waits for the acknowledge.
- Replaces the free-running hcount generator feeding ray_calculations.

Parameters:
- SCREEN_WIDTH, 320, columns issued per frame.
- HCOUNT_WIDTH, 9, width of column index.
- POSE_WIDTH, 16, width of each fixed-point pose field (8.8).
- MAX_INFLIGHT, 256, maximum issued-but-not-retired columns (matches DDA FIFO depth).
- FC_WIDTH, 8, width of rendered-frame counter.

Ports:
- pixel_clk_in  input  1  pixel clock; sole clock.
- rst_in  input  1  asynchronous, active-low reset.
- enable_in  input  1  level; 0 holds scheduler in IDLE after current frame.
- frame_start_in  input  1  one-cycle pulse from video_sig_gen new frame.
- pos_x_in, pos_y_in, dir_x_in, dir_y_in, plane_x_in, plane_y_in  input  POSE_WIDTH each  live pose from controller.
- pos_x_out, pos_y_out, dir_x_out, dir_y_out, plane_x_out, plane_y_out  output  POSE_WIDTH each  frame-stable pose snapshot.
- hcount_out  output  HCOUNT_WIDTH  column index to ray_calculations.
- col_valid_out  output  1  hcount_out valid.
- col_ready_in  input  1  ray calculation/FIFO accepts column.
- col_retire_in  input  1  pulse per column fully consumed by transformer.
- frame_done_in  input  1  pulse: transformer last pixel of frame.
- swap_req_out  output  1  level request to frame buffer to swap.
- swap_ack_in  input  1  pulse: swap performed.
- busy_out  output  1  high in any state except IDLE.
- frame_count_out  output  FC_WIDTH  completed frames, wraps.
- overrun_out  output  1  one-cycle pulse: frame_start_in seen while not IDLE.
- error_out  output  1  sticky protocol error.

Behaviour:
- Reset (rst_in=0, async): state IDLE; all outputs 0; issue counter, credit counter, frame_count cleared; error cleared.
- States: IDLE, SNAP, ISSUE, DRAIN, SWAP.
- IDLE: on frame_start_in && enable_in → SNAP. frame_start_in with enable_in=0 ignored, no overrun.
- SNAP: one cycle; latch all six pose inputs into *_out; issue counter ← 0; → ISSUE. Pose outputs are constant until the next SNAP.
- ISSUE: col_valid_out=1 iff outstanding < MAX_INFLIGHT. hcount_out = issue counter. hcount_out and col_valid_out are held stable while col_ready_in=0; once asserted, col_valid_out does not drop without a transfer. On transfer (valid && ready): counter+1, outstanding+1. Transfer at SCREEN_WIDTH-1 → DRAIN, col_valid_out=0 next cycle. Counter never reaches SCREEN_WIDTH.
- Credit: outstanding updates as +transfer −col_retire_in. A simultaneous transfer and retire leaves it unchanged. A retire at outstanding=0 is ignored and sets error_out. Outstanding is updated in all states.
- DRAIN: on frame_done_in → SWAP with swap_req_out=1 the next cycle.
- SWAP: hold swap_req_out=1 until swap_ack_in. On ack: swap_req_out=0, frame_count+1 (wraps), → IDLE. A frame_start_in arriving in the same cycle as the ack is reported as an overrun; that frame is not started.
- overrun_out pulses for frame_start_in in SNAP/ISSUE/DRAIN/SWAP. The current frame continues; no restart.
- error_out (sticky until reset) is set by:
  - frame_done_in in any state other than DRAIN;
  - swap_ack_in outside SWAP;
  - retire underflow;
  - outstanding ≠ 0 on leaving SWAP.
- Latency: frame_start_in → first col_valid_out = 2 cycles. Maximum throughput is 1 column per cycle.
- enable_in deasserted mid-frame: the frame completes normally, then the block stays in IDLE.

Decomposition:
- Shared package raycast_pkg:
  - sched_state_t enum (IDLE, SNAP, ISSUE, DRAIN, SWAP);
  - SCREEN_WIDTH, SCREEN_HEIGHT, HCOUNT_WIDTH constants;
  - pose_t packed struct of six POSE_WIDTH fields.
- One sub-module: credit_counter (up/down saturating-check counter with full flag and underflow error), reusable for other FIFO-backed stages.

Test Plan:
- Reset mid-ISSUE at hcount 100 → all outputs 0 immediately; next frame_start_in yields hcount_out=0 two cycles later.
- frame_start_in with col_ready_in=1, retire 1 cycle after each issue → exactly 320 transfers, hcount 0..319 in order, no 320. frame_done_in → swap_req_out=1. swap_ack_in → frame_count_out=1, busy_out=0.
- Random col_ready_in stalls (50%) → hcount_out and col_valid_out stable during stall; no duplicated or skipped index.
- No retires, ready always 1, MAX_INFLIGHT=256 → col_valid_out drops after hcount 255. One retire releases exactly one column (hcount 256).
- Pose inputs changed during ISSUE → pose outputs hold the SNAP values (e.g. pos_x_out=0x0C00) all frame.
- frame_start_in during DRAIN → overrun_out single pulse, frame unchanged. frame_done_in while IDLE → error_out=1 sticky. Retire at outstanding=0 → error_out=1.

Source files
------------

// File: rtl/raycast_pkg.sv
// Shared types and constants for the raycasting pipeline.
//   sched_state_t : frame scheduler states
//   pose_t        : six 8.8 fixed-point pose fields (pos, dir, plane)
package raycast_pkg;

  localparam int unsigned SCREEN_WIDTH  = 320;
  localparam int unsigned SCREEN_HEIGHT = 240;
  localparam int unsigned HCOUNT_WIDTH  = 9;
  localparam int unsigned POSE_WIDTH    = 16;
  localparam int unsigned MAX_INFLIGHT  = 256;
  localparam int unsigned FC_WIDTH      = 8;
  // Must hold MAX_INFLIGHT itself, not just MAX_INFLIGHT-1.
  localparam int unsigned CREDIT_WIDTH  = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [2:0] {
    IDLE,
    SNAP,
    ISSUE,
    DRAIN,
    SWAP
  } sched_state_t;

  typedef struct packed {
    logic [POSE_WIDTH-1:0] pos_x;
    logic [POSE_WIDTH-1:0] pos_y;
    logic [POSE_WIDTH-1:0] dir_x;
    logic [POSE_WIDTH-1:0] dir_y;
    logic [POSE_WIDTH-1:0] plane_x;
    logic [POSE_WIDTH-1:0] plane_y;
  } pose_t;

endpackage

// File: rtl/credit_counter.sv
// Up/down credit counter for FIFO-backed stages.
//   inc_in      : one item entered the stage
//   dec_in      : one item left the stage
//   count_out   : registered outstanding count
//   full_next_c : count after this cycle's update reaches MAX
//   underflow_c : dec_in with nothing outstanding (update ignored)
module credit_counter #(
  parameter int unsigned MAX = 256,
  parameter int unsigned W   = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_in,
  input  logic         dec_in,
  output logic [W-1:0] count_out,
  output logic         full_next_c,
  output logic         underflow_c
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // Simultaneous inc/dec cancels; saturate at both ends.
  always_comb begin
    count_d     = count_q;
    underflow_c = 1'b0;
    if (inc_in && !dec_in) begin
      if (count_q < W'(MAX)) begin
        count_d = count_q + W'(1);
      end
    end else if (dec_in && !inc_in) begin
      if (count_q == '0) begin
        underflow_c = 1'b1;
      end else begin
        count_d = count_q - W'(1);
      end
    end
    full_next_c = (count_d >= W'(MAX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;

endmodule

// File: rtl/ray_frame_scheduler.sv
// Per-frame scheduler for the raycasting pipeline.
// Snapshots the pose on each frame start, issues column indices
// 0..SCREEN_WIDTH-1 over a valid/ready handshake under a credit limit,
// then requests a frame-buffer swap once the transformer finishes.
//   pixel_clk_in / rst_in           : clock, async active-low reset
//   enable_in, frame_start_in       : frame control
//   *_in pose / *_out pose          : live pose / frame-stable snapshot
//   hcount_out, col_valid_out,
//   col_ready_in                    : column issue handshake
//   col_retire_in                   : column consumed downstream
//   frame_done_in                   : last pixel written
//   swap_req_out / swap_ack_in      : frame-buffer swap handshake
//   busy_out, frame_count_out,
//   overrun_out, error_out          : status
module ray_frame_scheduler
  import raycast_pkg::*;
(
  input  logic                    pixel_clk_in,
  input  logic                    rst_in,
  input  logic                    enable_in,
  input  logic                    frame_start_in,
  input  logic [POSE_WIDTH-1:0]   pos_x_in,
  input  logic [POSE_WIDTH-1:0]   pos_y_in,
  input  logic [POSE_WIDTH-1:0]   dir_x_in,
  input  logic [POSE_WIDTH-1:0]   dir_y_in,
  input  logic [POSE_WIDTH-1:0]   plane_x_in,
  input  logic [POSE_WIDTH-1:0]   plane_y_in,
  output logic [POSE_WIDTH-1:0]   pos_x_out,
  output logic [POSE_WIDTH-1:0]   pos_y_out,
  output logic [POSE_WIDTH-1:0]   dir_x_out,
  output logic [POSE_WIDTH-1:0]   dir_y_out,
  output logic [POSE_WIDTH-1:0]   plane_x_out,
  output logic [POSE_WIDTH-1:0]   plane_y_out,
  output logic [HCOUNT_WIDTH-1:0] hcount_out,
  output logic                    col_valid_out,
  input  logic                    col_ready_in,
  input  logic                    col_retire_in,
  input  logic                    frame_done_in,
  output logic                    swap_req_out,
  input  logic                    swap_ack_in,
  output logic                    busy_out,
  output logic [FC_WIDTH-1:0]     frame_count_out,
  output logic                    overrun_out,
  output logic                    error_out
);

  sched_state_t            state_d, state_q;
  logic [HCOUNT_WIDTH-1:0] hcount_d, hcount_q;
  logic                    col_valid_d, col_valid_q;
  logic                    swap_req_d, swap_req_q;
  logic                    busy_d, busy_q;
  logic [FC_WIDTH-1:0]     frame_count_d, frame_count_q;
  logic                    overrun_d, overrun_q;
  logic                    error_d, error_q;
  pose_t                   pose_d, pose_q;
  pose_t                   pose_live;

  logic                    xfer;
  logic                    credit_full_next;
  logic                    credit_underflow;
  logic [CREDIT_WIDTH-1:0] outstanding;

  assign pose_live = {pos_x_in, pos_y_in, dir_x_in, dir_y_in, plane_x_in, plane_y_in};
  assign xfer      = col_valid_q && col_ready_in;

  // Outstanding columns: +1 per transfer, -1 per retire, in every state.
  credit_counter #(
    .MAX (MAX_INFLIGHT),
    .W   (CREDIT_WIDTH)
  ) u_credit (
    .clk         (pixel_clk_in),
    .rst_n       (rst_in),
    .inc_in      (xfer),
    .dec_in      (col_retire_in),
    .count_out   (outstanding),
    .full_next_c (credit_full_next),
    .underflow_c (credit_underflow)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    hcount_d      = hcount_q;
    pose_d        = pose_q;
    frame_count_d = frame_count_q;

    case (state_q)
      IDLE: begin
        if (frame_start_in && enable_in) begin
          state_d = SNAP;
        end
      end
      SNAP: begin
        pose_d   = pose_live;
        hcount_d = '0;
        state_d  = ISSUE;
      end
      ISSUE: begin
        // Last index stays on hcount_q; it never advances past it.
        if (xfer) begin
          if (hcount_q == HCOUNT_WIDTH'(SCREEN_WIDTH - 1)) begin
            state_d = DRAIN;
          end else begin
            hcount_d = hcount_q + HCOUNT_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        if (frame_done_in) begin
          state_d = SWAP;
        end
      end
      SWAP: begin
        if (swap_ack_in) begin
          state_d       = IDLE;
          frame_count_d = frame_count_q + FC_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A stalled valid cannot lose credit (retires only free it), so it holds.
    col_valid_d = (state_d == ISSUE) && !credit_full_next;
    swap_req_d  = (state_d == SWAP);
    busy_d      = (state_d != IDLE);
    overrun_d   = frame_start_in && (state_q != IDLE);
    error_d     = error_q
                | (frame_done_in && (state_q != DRAIN))
                | (swap_ack_in && (state_q != SWAP))
                | credit_underflow
                | ((state_q == SWAP) && swap_ack_in && (outstanding != '0));
  end

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q       <= IDLE;
      hcount_q      <= '0;
      col_valid_q   <= 1'b0;
      swap_req_q    <= 1'b0;
      busy_q        <= 1'b0;
      frame_count_q <= '0;
      overrun_q     <= 1'b0;
      error_q       <= 1'b0;
      pose_q        <= '0;
    end else begin
      state_q       <= state_d;
      hcount_q      <= hcount_d;
      col_valid_q   <= col_valid_d;
      swap_req_q    <= swap_req_d;
      busy_q        <= busy_d;
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
      error_q       <= error_d;
      pose_q        <= pose_d;
    end
  end

  assign pos_x_out       = pose_q.pos_x;
  assign pos_y_out       = pose_q.pos_y;
  assign dir_x_out       = pose_q.dir_x;
  assign dir_y_out       = pose_q.dir_y;
  assign plane_x_out     = pose_q.plane_x;
  assign plane_y_out     = pose_q.plane_y;
  assign hcount_out      = hcount_q;
  assign col_valid_out   = col_valid_q;
  assign swap_req_out    = swap_req_q;
  assign busy_out        = busy_q;
  assign frame_count_out = frame_count_q;
  assign overrun_out     = overrun_q;
  assign error_out       = error_q;

endmodule
